// File: rtl/msrv32_load_unit_ctrl_if.sv
// Bundles the load request from the memory stage, the data-bus read
// channel and the load-unit results into one port.
// The master view belongs to the load unit. The slave view belongs to
// whatever drives the requests and answers the bus.
interface msrv32_load_unit_ctrl_if;
    logic        load_req_in;
    logic [1:0]  load_size_in;
    logic        load_unsigned_in;
    logic [31:0] iadder_out_in;
    logic [31:0] ms_riscv32_mp_dmdata_in;
    logic        ms_riscv32_mp_dmdata_valid_in;
    logic [31:0] dmaddr_out;
    logic        dmrd_req_out;
    logic [31:0] lu_output_out;
    logic        lu_valid_out;
    logic        stall_out;
    logic        misaligned_out;
    logic        bus_err_out;

    modport master (
        input  load_req_in,
        input  load_size_in,
        input  load_unsigned_in,
        input  iadder_out_in,
        input  ms_riscv32_mp_dmdata_in,
        input  ms_riscv32_mp_dmdata_valid_in,
        output dmaddr_out,
        output dmrd_req_out,
        output lu_output_out,
        output lu_valid_out,
        output stall_out,
        output misaligned_out,
        output bus_err_out
    );

    modport slave (
        output load_req_in,
        output load_size_in,
        output load_unsigned_in,
        output iadder_out_in,
        output ms_riscv32_mp_dmdata_in,
        output ms_riscv32_mp_dmdata_valid_in,
        input  dmaddr_out,
        input  dmrd_req_out,
        input  lu_output_out,
        input  lu_valid_out,
        input  stall_out,
        input  misaligned_out,
        input  bus_err_out
    );
endinterface

// File: rtl/msrv32_load_unit_ctrl.sv
// Data-memory read side of the msrv32 core.
// It issues a word-aligned read and waits for the bus, with a limit on how
// long it waits. It then extends the addressed byte, half or word and
// registers the result for the writeback selector.
module msrv32_load_unit_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input logic                      ms_riscv32_mp_clk_in,
    input logic                      ms_riscv32_mp_rst_in,
    msrv32_load_unit_ctrl_if.master  lu_bus
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    // Last wait cycle: the counter starts at 0 on entry to WAIT.
    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT_CYCLES - 1);

    state_t      state, next_state;
    logic [7:0]  wait_cnt, wait_cnt_next;
    logic        accept, misalign, capture, timeout;
    logic        addr_misaligned;
    logic [1:0]  lat_offset;
    logic [1:0]  lat_size;
    logic        lat_unsigned;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] ext_data;
    logic [31:0] dmaddr_q;
    logic [31:0] lu_output_q;
    logic        lu_valid_q;
    logic        misaligned_q;
    logic        bus_err_q;

    // Alignment check on the incoming request.
    // A half needs an even address. A word, or size 11, needs a multiple of four.
    always_comb begin
        addr_misaligned = 1'b0;
        case (lu_bus.load_size_in)
            2'b00:   addr_misaligned = 1'b0;
            2'b01:   addr_misaligned = lu_bus.iadder_out_in[0];
            default: addr_misaligned = (lu_bus.iadder_out_in[1:0] != 2'b00);
        endcase
    end

    // Next state and per-cycle decisions.
    // In WAIT, valid data wins over timeout, and new requests are ignored.
    always_comb begin
        next_state    = state;
        wait_cnt_next = wait_cnt;
        accept        = 1'b0;
        misalign      = 1'b0;
        capture       = 1'b0;
        timeout       = 1'b0;
        case (state)
            S_IDLE: begin
                if (lu_bus.load_req_in) begin
                    if (addr_misaligned) begin
                        misalign = 1'b1;
                    end else begin
                        accept        = 1'b1;
                        next_state    = S_WAIT;
                        wait_cnt_next = 8'd0;
                    end
                end
            end
            S_WAIT: begin
                if (lu_bus.ms_riscv32_mp_dmdata_valid_in) begin
                    capture    = 1'b1;
                    next_state = S_IDLE;
                end else if (wait_cnt == LAST_WAIT) begin
                    timeout    = 1'b1;
                    next_state = S_IDLE;
                end else begin
                    wait_cnt_next = wait_cnt + 8'd1;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Select the addressed lane of the bus data, using the offset, size and
    // signedness latched at accept time, then extend it.
    always_comb begin
        byte_sel = 8'h00;
        ext_data = 32'h0000_0000;
        case (lat_offset)
            2'b00: byte_sel = lu_bus.ms_riscv32_mp_dmdata_in[7:0];
            2'b01: byte_sel = lu_bus.ms_riscv32_mp_dmdata_in[15:8];
            2'b10: byte_sel = lu_bus.ms_riscv32_mp_dmdata_in[23:16];
            2'b11: byte_sel = lu_bus.ms_riscv32_mp_dmdata_in[31:24];
            default: byte_sel = 8'h00;
        endcase
        half_sel = lat_offset[1] ? lu_bus.ms_riscv32_mp_dmdata_in[31:16]
                                 : lu_bus.ms_riscv32_mp_dmdata_in[15:0];
        case (lat_size)
            2'b00:   ext_data = {{24{~lat_unsigned & byte_sel[7]}}, byte_sel};
            2'b01:   ext_data = {{16{~lat_unsigned & half_sel[15]}}, half_sel};
            default: ext_data = lu_bus.ms_riscv32_mp_dmdata_in;
        endcase
    end

    // State register and wait counter.
    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (!ms_riscv32_mp_rst_in) begin
            state    <= S_IDLE;
            wait_cnt <= 8'd0;
        end else begin
            state    <= next_state;
            wait_cnt <= wait_cnt_next;
        end
    end

    // Request latches, the registered result, and the status pulses.
    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (!ms_riscv32_mp_rst_in) begin
            dmaddr_q     <= 32'h0000_0000;
            lat_offset   <= 2'b00;
            lat_size     <= 2'b00;
            lat_unsigned <= 1'b0;
            lu_output_q  <= 32'h0000_0000;
            lu_valid_q   <= 1'b0;
            misaligned_q <= 1'b0;
            bus_err_q    <= 1'b0;
        end else begin
            lu_valid_q   <= capture;
            misaligned_q <= misalign;
            bus_err_q    <= timeout;
            if (accept) begin
                dmaddr_q     <= {lu_bus.iadder_out_in[31:2], 2'b00};
                lat_offset   <= lu_bus.iadder_out_in[1:0];
                lat_size     <= lu_bus.load_size_in;
                lat_unsigned <= lu_bus.load_unsigned_in;
            end
            if (capture) begin
                lu_output_q <= ext_data;
            end else if (timeout) begin
                lu_output_q <= 32'h0000_0000;
            end
        end
    end

    assign lu_bus.dmaddr_out     = dmaddr_q;
    assign lu_bus.dmrd_req_out   = (state == S_WAIT);
    assign lu_bus.lu_output_out  = lu_output_q;
    assign lu_bus.lu_valid_out   = lu_valid_q;
    assign lu_bus.misaligned_out = misaligned_q;
    assign lu_bus.bus_err_out    = bus_err_q;
    assign lu_bus.stall_out      = ms_riscv32_mp_rst_in & ((state == S_WAIT) | accept);

endmodule

// File: tb/tb_msrv32_load_unit_ctrl.sv
// Testbench for msrv32_load_unit_ctrl with a short timeout.
// A transaction-level model predicts each load: the misalignment rule,
// arithmetic extraction of the addressed lane, and the completion cycle
// (data or timeout).
module tb_msrv32_load_unit_ctrl;

    localparam int unsigned TIMEOUT = 4;

    logic clk;
    logic rst_n;
    int   compared;
    int   mismatched;
    logic [31:0] model_out;
    logic [31:0] model_addr;

    msrv32_load_unit_ctrl_if bus ();

    msrv32_load_unit_ctrl #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .ms_riscv32_mp_clk_in (clk),
        .ms_riscv32_mp_rst_in (rst_n),
        .lu_bus               (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic req, input logic [31:0] addr, input logic [1:0] size,
                                 input logic uns, input logic [31:0] data, input logic valid);
        bus.load_req_in                   = req;
        bus.iadder_out_in                 = addr;
        bus.load_size_in                  = size;
        bus.load_unsigned_in              = uns;
        bus.ms_riscv32_mp_dmdata_in       = data;
        bus.ms_riscv32_mp_dmdata_valid_in = valid;
    endtask

    function automatic bit modelMisaligned(input logic [31:0] addr, input logic [1:0] size);
        if (size == 2'd0) return 1'b0;
        if (size == 2'd1) return (addr % 2) != 0;
        return (addr % 4) != 0;
    endfunction

    function automatic logic [31:0] modelExtract(input logic [31:0] data, input logic [31:0] addr,
                                                 input logic [1:0] size, input logic uns);
        longint v;
        int unsigned sh;
        if (size == 2'd0) begin
            sh = (addr % 4) * 8;
            v  = longint'((data >> sh) & 32'hFF);
            if (!uns && v >= 128) v = v - 256;
        end else if (size == 2'd1) begin
            sh = ((addr % 4) / 2) * 16;
            v  = longint'((data >> sh) & 32'hFFFF);
            if (!uns && v >= 32768) v = v - 65536;
        end else begin
            v = longint'(data);
        end
        return v[31:0];
    endfunction

    // Check the registered outputs that should be quiet in a plain IDLE cycle.
    task automatic checkQuiet(input string tag);
        checkOutput({tag, "_valid"}, 32'(bus.lu_valid_out), 32'd0);
        checkOutput({tag, "_req"}, 32'(bus.dmrd_req_out), 32'd0);
        checkOutput({tag, "_err"}, 32'(bus.bus_err_out), 32'd0);
        checkOutput({tag, "_mis"}, 32'(bus.misaligned_out), 32'd0);
        checkOutput({tag, "_out"}, bus.lu_output_out, model_out);
        checkOutput({tag, "_addr"}, bus.dmaddr_out, model_addr);
    endtask

    // One IDLE cycle with no request. A stray valid must be ignored.
    task automatic idleCycle(input logic stray_valid);
        applyStimulus(1'b0, $urandom, 2'($urandom), 1'($urandom), $urandom, stray_valid);
        #1 checkOutput("idle_stall", 32'(bus.stall_out), 32'd0);
        @(negedge clk);
        checkQuiet("idle");
    endtask

    // One load from request to completion. k is the wait cycle on which
    // valid arrives; k > TIMEOUT means the bus never answers. The task is
    // entered and left at a negedge.
    task automatic runLoad(input logic [31:0] addr, input logic [1:0] size, input logic uns,
                           input logic [31:0] data, input int k);
        bit mis;
        int c;
        mis = modelMisaligned(addr, size);
        applyStimulus(1'b1, addr, size, uns, $urandom, 1'b0);
        #1 checkOutput("req_stall", 32'(bus.stall_out), mis ? 32'd0 : 32'd1);
        @(negedge clk);
        if (mis) begin
            checkOutput("mis_pulse", 32'(bus.misaligned_out), 32'd1);
            checkOutput("mis_req", 32'(bus.dmrd_req_out), 32'd0);
            checkOutput("mis_valid", 32'(bus.lu_valid_out), 32'd0);
            checkOutput("mis_out", bus.lu_output_out, model_out);
            return;
        end
        model_addr = addr & 32'hFFFF_FFFC;
        c = 1;
        while (1) begin
            checkOutput("wait_req", 32'(bus.dmrd_req_out), 32'd1);
            checkOutput("wait_addr", bus.dmaddr_out, model_addr);
            checkOutput("wait_valid", 32'(bus.lu_valid_out), 32'd0);
            checkOutput("wait_err", 32'(bus.bus_err_out), 32'd0);
            checkOutput("wait_out", bus.lu_output_out, model_out);
            applyStimulus(1'($urandom), $urandom, 2'($urandom), 1'($urandom),
                          (c == k) ? data : $urandom, (c == k));
            #1 checkOutput("wait_stall", 32'(bus.stall_out), 32'd1);
            @(negedge clk);
            if (c == k || c == int'(TIMEOUT)) break;
            c++;
        end
        if (k <= int'(TIMEOUT)) begin
            model_out = modelExtract(data, addr, size, uns);
            checkOutput("done_valid", 32'(bus.lu_valid_out), 32'd1);
            checkOutput("done_err", 32'(bus.bus_err_out), 32'd0);
        end else begin
            model_out = 32'd0;
            checkOutput("tmo_err", 32'(bus.bus_err_out), 32'd1);
            checkOutput("tmo_valid", 32'(bus.lu_valid_out), 32'd0);
        end
        checkOutput("done_out", bus.lu_output_out, model_out);
        checkOutput("done_req", 32'(bus.dmrd_req_out), 32'd0);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        model_out  = 32'd0;
        model_addr = 32'd0;

        // Reset held low with an aligned request pending.
        rst_n = 1'b0;
        applyStimulus(1'b1, 32'h100, 2'd2, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("rst_stall", 32'(bus.stall_out), 32'd0);
            checkQuiet("rst");
        end
        rst_n = 1'b1;
        idleCycle(1'b0);

        // Directed loads.
        $display("[TB] directed loads");
        runLoad(32'h1003, 2'd0, 1'b0, 32'h80AA_BBCC, 1);
        checkOutput("lb_result", bus.lu_output_out, 32'hFFFF_FF80);
        idleCycle(1'b0);
        runLoad(32'h1003, 2'd0, 1'b1, 32'h80AA_BBCC, 1);
        checkOutput("lbu_result", bus.lu_output_out, 32'h0000_0080);
        runLoad(32'h2002, 2'd1, 1'b0, 32'h7FFF_1234, 3);
        checkOutput("lh_result", bus.lu_output_out, 32'h0000_7FFF);
        runLoad(32'h2001, 2'd1, 1'b0, 32'h0, 1);
        idleCycle(1'b1);
        runLoad(32'h3000, 2'd2, 1'b0, 32'h1234_5678, TIMEOUT + 1);
        checkOutput("tmo_result", bus.lu_output_out, 32'h0);
        idleCycle(1'b0);
        runLoad(32'h3000, 2'd2, 1'b0, 32'h1234_5678, TIMEOUT);
        checkOutput("edge_result", bus.lu_output_out, 32'h1234_5678);
        runLoad(32'h10, 2'd2, 1'b0, 32'hCAFE_0010, 1);
        runLoad(32'h14, 2'd3, 1'b1, 32'hBEEF_0014, 1);
        checkOutput("b2b_result", bus.lu_output_out, 32'hBEEF_0014);

        // Reset during a wait aborts the read. A later valid is ignored.
        $display("[TB] reset during wait");
        idleCycle(1'b0);
        applyStimulus(1'b1, 32'h40, 2'd2, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        checkOutput("abort_req1", 32'(bus.dmrd_req_out), 32'd1);
        applyStimulus(1'b0, 32'h0, 2'd0, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1 checkOutput("abort_stall", 32'(bus.stall_out), 32'd0);
        @(negedge clk);
        model_out  = 32'd0;
        model_addr = 32'd0;
        checkQuiet("abort");
        rst_n = 1'b1;
        applyStimulus(1'b0, 32'h0, 2'd2, 1'b0, 32'hDEAD_BEEF, 1'b1);
        #1 checkOutput("late_stall", 32'(bus.stall_out), 32'd0);
        @(negedge clk);
        checkQuiet("late");

        // Randomized loads against the model.
        $display("[TB] random loads");
        for (int n = 0; n < 80; n++) begin
            logic [31:0] a;
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = (a[0] && $urandom_range(0, 1) == 1) ? 2'b00 : a[1:0];
            runLoad(a, 2'($urandom), 1'($urandom), $urandom, int'($urandom_range(1, TIMEOUT + 1)));
            if ($urandom_range(0, 2) == 0) idleCycle(1'($urandom));
        end
        idleCycle(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/msrv32_load_unit_ctrl.md
# msrv32_load_unit_ctrl

Data-memory read side of the msrv32 RV32I core: accepts a load request carrying the effective address from the immediate adder and issues a word-aligned read on the data bus. It waits for the bus with a bounded wait-state counter, then extracts and sign- or zero-extends the addressed byte, half or word. It registers the result as the load-unit output consumed by the writeback selector, and stalls the pipeline while the read is outstanding.

## Interface
- TIMEOUT_CYCLES, 255: maximum WAIT cycles without data-valid before a bus error; legal range 1..255.
- ms_riscv32_mp_clk_in  input  1  core clock; all state updates on the rising edge.
- ms_riscv32_mp_rst_in  input  1  reset, synchronous, active-low.
- load_req_in  input  1  a load instruction is in the memory stage this cycle.
- load_size_in  input  2  00 byte, 01 half, 10 word, 11 treated as word.
- load_unsigned_in  input  1  1 = zero-extend (LBU/LHU), 0 = sign-extend.
- iadder_out_in  input  32  effective byte address.
- ms_riscv32_mp_dmdata_in  input  32  read data from the data bus.
- ms_riscv32_mp_dmdata_valid_in  input  1  read data valid (bus ready).
- dmaddr_out  output  32  word-aligned bus address {addr[31:2],2'b00}.
- dmrd_req_out  output  1  read request, held high for the whole of WAIT.
- lu_output_out  output  32  extended load result (registered).
- lu_valid_out  output  1  one-cycle pulse: lu_output_out is new.
- stall_out  output  1  hold upstream pipeline.
- misaligned_out  output  1  one-cycle pulse: load address misaligned, no bus access.
- bus_err_out  output  1  one-cycle pulse: timeout expired.

## Operation
- Two-state FSM: IDLE, WAIT.
- IDLE with load_req_in=1:
  - Misaligned: half with addr[0]=1, or word/11 with addr[1:0]!=0. Pulse misaligned_out next cycle, stay in IDLE, no request.
  - Aligned: latch the address, addr[1:0], size and unsigned; set dmaddr_out; go to WAIT; clear the wait counter.
- WAIT: dmrd_req_out=1 and the counter increments each cycle.
  - valid=1: capture the extracted data, pulse lu_valid_out, return to IDLE. This takes priority over timeout in the same cycle.
  - Counter reaches TIMEOUT_CYCLES with valid=0: lu_output_out <= 0, pulse bus_err_out, return to IDLE.
- load_req_in is ignored in WAIT because the pipeline is stalled.
- Extraction:
  - Byte: lane addr[1:0] (00 = bits 7:0 … 11 = bits 31:24), extended from bit 7.
  - Half: lane addr[1] (0 = 15:0, 1 = 31:16), extended from bit 15.
  - Word: unchanged; load_unsigned_in is ignored.
- stall_out = (state==WAIT) | (state==IDLE & load_req_in & aligned), combinational.
- lu_output_out holds its last value until the next capture, bus error or reset.
- dmaddr_out holds its value after returning to IDLE.

## Timing
- Reset (ms_riscv32_mp_rst_in=0 at a clock edge): state IDLE, counter 0, all outputs 0, including stall_out, which is forced to 0 while reset is low.
- Reset in WAIT aborts the read: dmrd_req_out is 0 the next cycle and no lu_valid_out pulse is produced.
- Aligned request in cycle N:
  - stall_out=1 in N.
  - dmrd_req_out=1 and dmaddr_out valid from N+1.
- valid=1 in cycle N+k (k≥1): lu_output_out/lu_valid_out in N+k+1, dmrd_req_out=0 and stall_out=0 in N+k+1. Minimum latency is 2 cycles.
- Timeout: bus_err_out in cycle N+TIMEOUT_CYCLES+1 when no valid is seen.
- Misaligned request in N: misaligned_out in N+1, stall_out=0 throughout, dmrd_req_out stays 0.
- A new request is accepted in the same cycle lu_valid_out pulses (back-to-back loads, no idle gap).
- valid=1 while in IDLE is ignored.

## Test plan
- Reset: hold reset low 3 cycles with load_req_in=1 -> all outputs 0. After release, IDLE with no request.
- LB, addr 0x1003, data 0x80AA_BBCC, valid at N+1 -> dmaddr_out=0x1000. At N+2: lu_output_out=0xFFFF_FF80 and lu_valid_out=1; the same case as LBU gives 0x0000_0080.
- LH, addr 0x2002, data 0x7FFF_1234, valid at N+3 -> stall_out high N..N+3, lu_output_out=0x0000_7FFF at N+4. LH at 0x2001 -> misaligned_out pulse at N+1, no dmrd_req_out.
- LW, addr 0x3000, TIMEOUT_CYCLES=4, valid never -> bus_err_out at N+5, lu_output_out=0, IDLE at N+5. Second run with valid exactly at the timeout cycle -> lu_valid_out, no bus_err_out.
- Back-to-back LW 0x10 then LW 0x14 with zero-wait bus -> two lu_valid_out pulses 2 cycles apart, dmaddr_out 0x10 then 0x14.
- Reset asserted at N+2 of a 5-cycle wait -> dmrd_req_out=0 at N+3, no lu_valid_out. A late valid is ignored.
